// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: IDLE/RUN/HALT sequencer driving the PC, ROM address and IF/ID register.
// One-edge fetch latency; Stall holds PC and IF/ID, Jump/Branch redirect overrides Stall and inserts a bubble.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             HaltReq,
    input  logic             Stall,
    input  logic             Jump,
    input  logic [25:0]      JIndex,
    input  logic             Branch,
    input  logic [15:0]      BrImm,
    input  logic [31:0]      IdPC4,
    output logic [31:0]      Addr,
    input  logic [31:0]      INST,
    output logic [31:0]      IF_ID_INST,
    output logic [31:0]      IF_ID_PC4,
    output logic             IF_ID_Valid,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] FetchCnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic [31:0]        pc4_q, pc4_d;
    logic               vld_q, vld_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        pc_plus4;
    logic [31:0]        jmp_target;
    logic [31:0]        br_target;

    assign pc_plus4   = pc_q + 32'd4;
    assign jmp_target = {IdPC4[31:28], JIndex, 2'b00};
    assign br_target  = IdPC4 + {{14{BrImm[15]}}, BrImm, 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = HaltReq ? HALT : RUN;
                end
            end
            RUN: begin
                if (HaltReq) begin
                    state_d = HALT;
                end
                // A redirect still lands even on the halting cycle; halting alone freezes the PC.
                if (Jump || Branch) begin
                    pc_d   = Jump ? jmp_target : br_target;
                    inst_d = 32'd0;
                    pc4_d  = 32'd0;
                    vld_d  = 1'b0;
                end else if (HaltReq) begin
                    inst_d = 32'd0;
                    pc4_d  = 32'd0;
                    vld_d  = 1'b0;
                end else if (!Stall) begin
                    pc_d   = pc_plus4;
                    inst_d = INST;
                    pc4_d  = pc_plus4;
                    vld_d  = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            HALT: begin
                inst_d = 32'd0;
                pc4_d  = 32'd0;
                vld_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            pc4_q   <= 32'd0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Addr        = pc_q;
    assign IF_ID_INST  = inst_q;
    assign IF_ID_PC4   = pc4_q;
    assign IF_ID_Valid = vld_q;
    assign State       = state_q;
    assign FetchCnt    = cnt_q;

endmodule
